// File: rtl/ex_mem_stage.sv
// Execute stage with EX/MEM pipeline register for the 5-stage MIPS datapath.
// Includes a shift-add unsigned multiplier feeding HI/LO; stall freezes upstream while it runs.
module ex_mem_stage #(
    parameter int MUL_CYCLES = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  wb_ctl,
    input  logic [2:0]  m_ctl,
    input  logic [3:0]  ex_ctl,
    input  logic [31:0] npc,
    input  logic [31:0] rdata1,
    input  logic [31:0] rdata2,
    input  logic [31:0] s_extend,
    input  logic [4:0]  instr_2016,
    input  logic [4:0]  instr_1511,
    output logic [1:0]  wb_ctlout,
    output logic        branch,
    output logic        memread,
    output logic        memwrite,
    output logic [31:0] add_result,
    output logic        zero,
    output logic [31:0] alu_result,
    output logic [31:0] rdata2out,
    output logic [4:0]  muxout,
    output logic        stall
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} mul_state_t;

    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] LAST_COUNT = 6'(MUL_CYCLES - 1);

    mul_state_t  state_r;
    logic [5:0]  count_r;
    logic [63:0] mcand_r;
    logic [31:0] mplier_r;
    logic [63:0] prod_r;
    logic [31:0] hi_r;
    logic [31:0] lo_r;

    logic [1:0]  wb_r;
    logic        branch_r, memread_r, memwrite_r, zero_r;
    logic [31:0] add_r, alu_r, rdata2_r;
    logic [4:0]  dest_r;

    logic [31:0] op_b_s;
    logic [31:0] alu_s;
    logic [31:0] target_s;
    logic [4:0]  dest_s;
    logic        is_multu_s;
    logic        bubble_s;
    logic [63:0] prod_add_s;

    // ALU operand select, function decode and destination select
    always_comb begin
        op_b_s     = ex_ctl[0] ? s_extend : rdata2;
        dest_s     = ex_ctl[3] ? instr_1511 : instr_2016;
        target_s   = npc + {s_extend[29:0], 2'b00};
        is_multu_s = 1'b0;
        alu_s      = 32'd0;
        case (ex_ctl[2:1])
            2'b00, 2'b11: alu_s = rdata1 + op_b_s;
            2'b01:        alu_s = rdata1 - op_b_s;
            2'b10: begin
                case (s_extend[5:0])
                    F_ADD:   alu_s = rdata1 + op_b_s;
                    F_SUB:   alu_s = rdata1 - op_b_s;
                    F_AND:   alu_s = rdata1 & op_b_s;
                    F_OR:    alu_s = rdata1 | op_b_s;
                    F_SLT:   alu_s = ($signed(rdata1) < $signed(op_b_s)) ? 32'd1 : 32'd0;
                    F_MFHI:  alu_s = hi_r;
                    F_MFLO:  alu_s = lo_r;
                    F_MULTU: is_multu_s = 1'b1;
                    default: alu_s = 32'd0;
                endcase
            end
            default: alu_s = 32'd0;
        endcase
    end

    // A multu in flight, or the multu itself, must not reach the memory stage
    assign bubble_s   = (state_r == BUSY) || is_multu_s;
    assign prod_add_s = mplier_r[0] ? (prod_r + mcand_r) : prod_r;

    // Multiplier FSM: shift-add one multiplier bit per cycle, LSB first
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r  <= IDLE;
            count_r  <= 6'd0;
            mcand_r  <= 64'd0;
            mplier_r <= 32'd0;
            prod_r   <= 64'd0;
            hi_r     <= 32'd0;
            lo_r     <= 32'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (is_multu_s) begin
                        state_r  <= BUSY;
                        mcand_r  <= {32'd0, rdata1};
                        mplier_r <= rdata2;
                        prod_r   <= 64'd0;
                        count_r  <= 6'd0;
                    end
                end
                BUSY: begin
                    prod_r   <= prod_add_s;
                    mcand_r  <= {mcand_r[62:0], 1'b0};
                    mplier_r <= {1'b0, mplier_r[31:1]};
                    count_r  <= count_r + 6'd1;
                    if (count_r == LAST_COUNT) begin
                        hi_r    <= prod_add_s[63:32];
                        lo_r    <= prod_add_s[31:0];
                        state_r <= IDLE;
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    // EX/MEM pipeline register, loading a bubble while the multiplier owns the stage
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wb_r       <= 2'd0;
            branch_r   <= 1'b0;
            memread_r  <= 1'b0;
            memwrite_r <= 1'b0;
            add_r      <= 32'd0;
            zero_r     <= 1'b0;
            alu_r      <= 32'd0;
            rdata2_r   <= 32'd0;
            dest_r     <= 5'd0;
        end else if (bubble_s) begin
            wb_r       <= 2'd0;
            branch_r   <= 1'b0;
            memread_r  <= 1'b0;
            memwrite_r <= 1'b0;
            add_r      <= 32'd0;
            zero_r     <= 1'b0;
            alu_r      <= 32'd0;
            rdata2_r   <= 32'd0;
            dest_r     <= 5'd0;
        end else begin
            wb_r       <= wb_ctl;
            branch_r   <= m_ctl[2];
            memread_r  <= m_ctl[1];
            memwrite_r <= m_ctl[0];
            add_r      <= target_s;
            zero_r     <= (alu_s == 32'd0);
            alu_r      <= alu_s;
            rdata2_r   <= rdata2;
            dest_r     <= dest_s;
        end
    end

    assign wb_ctlout  = wb_r;
    assign branch     = branch_r;
    assign memread    = memread_r;
    assign memwrite   = memwrite_r;
    assign add_result = add_r;
    assign zero       = zero_r;
    assign alu_result = alu_r;
    assign rdata2out  = rdata2_r;
    assign muxout     = dest_r;
    assign stall      = (state_r == BUSY);

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: behavioural model plus directed literal checks.
module tb_ex_mem_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  wb_ctl;
    logic [2:0]  m_ctl;
    logic [3:0]  ex_ctl;
    logic [31:0] npc, rdata1, rdata2, s_extend;
    logic [4:0]  instr_2016, instr_1511;
    logic [1:0]  wb_ctlout;
    logic        branch, memread, memwrite, zero, stall;
    logic [31:0] add_result, alu_result, rdata2out;
    logic [4:0]  muxout;

    int checks = 0;
    int failures = 0;

    // Model state: cycles of multiply left, architectural HI/LO, pending product
    int          busy_left = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    logic [63:0] m_pend = 64'd0;

    always #5 clk = ~clk;

    ex_mem_stage #(.MUL_CYCLES(32)) dut (
        .clk(clk), .reset(reset), .wb_ctl(wb_ctl), .m_ctl(m_ctl), .ex_ctl(ex_ctl),
        .npc(npc), .rdata1(rdata1), .rdata2(rdata2), .s_extend(s_extend),
        .instr_2016(instr_2016), .instr_1511(instr_1511),
        .wb_ctlout(wb_ctlout), .branch(branch), .memread(memread), .memwrite(memwrite),
        .add_result(add_result), .zero(zero), .alu_result(alu_result),
        .rdata2out(rdata2out), .muxout(muxout), .stall(stall)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic clr_in();
        wb_ctl = 2'd0; m_ctl = 3'd0; ex_ctl = 4'd0;
        npc = 32'd0; rdata1 = 32'd0; rdata2 = 32'd0; s_extend = 32'd0;
        instr_2016 = 5'd0; instr_1511 = 5'd0;
    endtask

    task automatic rand_in();
        logic [31:0] r;
        logic [5:0]  f;
        r = $urandom;
        case ($urandom_range(0, 9))
            0: f = 6'b100000;
            1: f = 6'b100010;
            2: f = 6'b100100;
            3: f = 6'b100101;
            4: f = 6'b101010;
            5: f = 6'b010000;
            6: f = 6'b010010;
            7: f = 6'b011001;
            default: f = 6'($urandom);
        endcase
        wb_ctl = 2'($urandom); m_ctl = 3'($urandom); ex_ctl = 4'($urandom);
        npc = $urandom; rdata1 = $urandom; s_extend = {r[31:6], f};
        rdata2 = ($urandom_range(0, 5) == 0) ? rdata1 : $urandom;
        instr_2016 = 5'($urandom); instr_1511 = 5'($urandom);
    endtask

    // One clock: predict from the current inputs, advance the model, compare after the edge
    task automatic step();
        logic [1:0]  e_wb;
        logic        e_br, e_mr, e_mw, e_zero, mul;
        logic [31:0] e_add, e_alu, e_rd2, b;
        logic [4:0]  e_dst;
        mul = (ex_ctl[2:1] == 2'b10) && (s_extend[5:0] == 6'b011001);
        e_wb = 2'd0; e_br = 1'b0; e_mr = 1'b0; e_mw = 1'b0; e_zero = 1'b0;
        e_add = 32'd0; e_alu = 32'd0; e_rd2 = 32'd0; e_dst = 5'd0;
        if (reset && busy_left == 0 && !mul) begin
            b = ex_ctl[0] ? s_extend : rdata2;
            if (ex_ctl[2:1] == 2'b01) e_alu = rdata1 - b;
            else if (ex_ctl[2:1] != 2'b10) e_alu = rdata1 + b;
            else begin
                case (s_extend[5:0])
                    6'b100000: e_alu = rdata1 + b;
                    6'b100010: e_alu = rdata1 - b;
                    6'b100100: e_alu = rdata1 & b;
                    6'b100101: e_alu = rdata1 | b;
                    6'b101010: e_alu = ($signed(rdata1) < $signed(b)) ? 32'd1 : 32'd0;
                    6'b010000: e_alu = m_hi;
                    6'b010010: e_alu = m_lo;
                    default:   e_alu = 32'd0;
                endcase
            end
            e_wb = wb_ctl; e_br = m_ctl[2]; e_mr = m_ctl[1]; e_mw = m_ctl[0];
            e_add = npc + s_extend * 32'd4;
            e_zero = (e_alu == 32'd0);
            e_rd2 = rdata2;
            e_dst = ex_ctl[3] ? instr_1511 : instr_2016;
        end
        @(posedge clk);
        if (!reset) begin
            busy_left = 0; m_hi = 32'd0; m_lo = 32'd0;
        end else if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) begin
                m_hi = m_pend[63:32];
                m_lo = m_pend[31:0];
            end
        end else if (mul) begin
            busy_left = 32;
            m_pend = 64'(rdata1) * 64'(rdata2);
        end
        #1;
        chk("wb_ctlout", 32'(wb_ctlout), 32'(e_wb));
        chk("branch", 32'(branch), 32'(e_br));
        chk("memread", 32'(memread), 32'(e_mr));
        chk("memwrite", 32'(memwrite), 32'(e_mw));
        chk("add_result", add_result, e_add);
        chk("zero", 32'(zero), 32'(e_zero));
        chk("alu_result", alu_result, e_alu);
        chk("rdata2out", rdata2out, e_rd2);
        chk("muxout", 32'(muxout), 32'(e_dst));
        chk("stall", 32'(stall), (busy_left > 0) ? 32'd1 : 32'd0);
    endtask

    task automatic rtype(input logic [5:0] f, input logic [31:0] a, input logic [31:0] bb);
        clr_in();
        wb_ctl = 2'b10; ex_ctl = 4'b1100; rdata1 = a; rdata2 = bb;
        s_extend = {26'd0, f}; instr_1511 = 5'd3;
    endtask

    // Runs an accepted multu to completion, counting cycles with stall high
    task automatic run_multu(input logic [31:0] a, input logic [31:0] bb);
        int cnt;
        rtype(6'b011001, a, bb);
        step();
        chk("multu_stall_start", 32'(stall), 32'd1);
        cnt = (stall === 1'b1) ? 1 : 0;
        for (int k = 0; k < 40 && stall === 1'b1; k++) begin
            step();
            if (stall === 1'b1) cnt++;
        end
        chk("multu_stall_cycles", 32'(cnt), 32'd32);
    endtask

    initial begin
        clr_in();
        // Reset held low with random inputs
        for (int i = 0; i < 5; i++) begin
            rand_in();
            #3;
            step();
        end
        chk("reset_stall", 32'(stall), 32'd0);
        reset = 1'b1;

        // R-type add
        clr_in();
        wb_ctl = 2'b10; ex_ctl = 4'b1100; rdata1 = 32'h0000A000; rdata2 = 32'h00000440;
        s_extend = 32'h00000020; instr_1511 = 5'd7;
        step();
        chk("add_lit", alu_result, 32'h0000A440);
        chk("add_dst_lit", 32'(muxout), 32'd7);
        chk("add_wb_lit", 32'(wb_ctlout), 32'd2);

        // Branch compare
        clr_in();
        ex_ctl = 4'b0010; rdata1 = 32'h12345678; rdata2 = 32'h12345678;
        m_ctl = 3'b100; npc = 32'h002A0A45; s_extend = 32'h0000000F;
        step();
        chk("br_zero_lit", 32'(zero), 32'd1);
        chk("br_branch_lit", 32'(branch), 32'd1);
        chk("br_target_lit", add_result, 32'h002A0A81);

        // Load address
        clr_in();
        ex_ctl = 4'b0001; rdata1 = 32'h000FC865; s_extend = 32'h000000AA;
        instr_2016 = 5'h15; m_ctl = 3'b010; wb_ctl = 2'b11;
        step();
        chk("ld_alu_lit", alu_result, 32'h000FC90F);
        chk("ld_dst_lit", 32'(muxout), 32'h15);
        chk("ld_memread_lit", 32'(memread), 32'd1);

        // MULTU 0xFFFFFFFF * 2 then read back LO/HI
        run_multu(32'hFFFFFFFF, 32'd2);
        rtype(6'b010010, 32'd0, 32'd0);
        step();
        chk("mflo1_lit", alu_result, 32'hFFFFFFFE);
        rtype(6'b010000, 32'd0, 32'd0);
        step();
        chk("mfhi1_lit", alu_result, 32'h00000001);

        // MULTU 7 * 6
        run_multu(32'd7, 32'd6);
        rtype(6'b010010, 32'd0, 32'd0);
        step();
        chk("mflo2_lit", alu_result, 32'd42);
        rtype(6'b010000, 32'd0, 32'd0);
        step();
        chk("mfhi2_lit", alu_result, 32'd0);

        // Reset during BUSY aborts asynchronously and clears HI/LO
        rtype(6'b011001, 32'd5, 32'd9);
        step();
        for (int i = 0; i < 10; i++) step();
        chk("mid_stall_before", 32'(stall), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("mid_stall_async", 32'(stall), 32'd0);
        busy_left = 0; m_hi = 32'd0; m_lo = 32'd0;
        step();
        reset = 1'b1;
        rtype(6'b010010, 32'd0, 32'd0);
        step();
        chk("mid_mflo_lit", alu_result, 32'd0);
        rtype(6'b010000, 32'd0, 32'd0);
        step();
        chk("mid_mfhi_lit", alu_result, 32'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            rand_in();
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
